load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Parametrised load/store unit: base register + signed offset -> effective address,
//  then byte/half/word/double access to a local data memory with sign/zero extension.
//  Holds its own register file (x0 hard-wired zero) plus a preload port.
//  Sits between the decode stage and data memory; valid/ready request, pulsed response.
// PARAMETERS
//  XLEN       64   data/address width in bits (32 or 64)
//  NREGS      32   register-file entries; RIDX_W = $clog2(NREGS)
//  MEM_BYTES  256  data-memory size in bytes (power of two)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       unit idle, request accepted when valid&&ready
//  req_store    in   1       1 = store, 0 = load
//  req_size     in   2       00 B, 01 H, 10 W, 11 D (D is illegal when XLEN=32 -> rsp_err)
//  req_unsigned in   1       load: zero-extend instead of sign-extend
//  rs1          in   RIDX_W  base register index
//  rd_rs2       in   RIDX_W  load destination / store source register index
//  offset       in   XLEN    signed byte offset
//  rf_we        in   1       preload write enable (honoured in IDLE only)
//  rf_widx      in   RIDX_W  preload index
//  rf_wdata     in   XLEN    preload data
//  rsp_valid    out  1       one-cycle response pulse
//  rsp_addr     out  XLEN    effective address of the completed request
//  rsp_data     out  XLEN    extended load value, or the stored data (size-masked)
//  rsp_err      out  1       request aborted: no memory or register update
//  busy         out  1       ~req_ready
// BEHAVIOUR
//  - Reset: FSM IDLE, req_ready=1, busy=0, rsp_* = 0, all registers = 0. Memory not reset.
//  - FSM: IDLE -> (accept) ADDR -> MEM -> WB -> IDLE. Accept at cycle T, rsp_valid at T+3.
//    Throughput: one request per 4 cycles; req_ready low in ADDR/MEM/WB.
//  - IDLE: latch request fields; rf_we writes rf[rf_widx] (idx 0 ignored). rf_we is
//    ignored in all other states. Same-cycle rf_we + accept: write lands first, ADDR sees it.
//  - ADDR: ea = rf[rs1] + offset, modulo 2^XLEN (wraps, no carry out); read rf[rd_rs2].
//    Error if ea >= MEM_BYTES, illegal size, or misaligned (see CONFIGURATION).
//  - MEM: little-endian. Store writes low 2^size bytes of rf[rd_rs2] at ea..ea+2^size-1;
//    load reads same bytes (synchronous read). Skipped on error.
//  - WB: load writes extended value to rf[rd_rs2] unless rd_rs2==0 or error;
//    rsp_valid=1, rsp_addr=ea, rsp_data = value (0 on error), rsp_err as computed.
//  - rsp_* hold their last value between pulses; only rsp_valid returns to 0.
//  - rst_n low in any state: immediate return to IDLE, pending request dropped,
//    no rsp_valid; a store already in MEM may or may not have written memory.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined: ea not a multiple of 2^size -> rsp_err=1, no access.
//  Not defined: low log2(2^size) bits of ea forced to 0 for the access; rsp_addr
//  reports the aligned address; no misalignment error.
// STRUCTURE
//  lsu_pkg: size encoding enum (SZ_B/H/W/D), FSM state enum, byte-mask/extend functions.
//  Sub-module lsu_dmem: byte-addressable MEM_BYTES memory, byte-enable write, sync read.
//  Register file and FSM stay in load_store_unit.
// TESTING (XLEN=64, NREGS=32, MEM_BYTES=256)
//  1 Preload x2=0x10, x6=0xFFFF_FFFF_FFFF_FF80; store D rs1=2 rd_rs2=6 off=8 ->
//    rsp_valid at T+3, rsp_addr=0x18, rsp_data=0xFFFF_FFFF_FFFF_FF80, err=0.
//  2 Load B rs1=2 rd_rs2=7 off=8 signed -> x7=0xFFFF_FFFF_FFFF_FF80; unsigned -> 0x80.
//  3 Load D rs1=2 rd_rs2=0 off=8 -> rsp_data=0xFFFF_FFFF_FFFF_FF80, x0 reads 0 after.
//  4 Load H rs1=2 off=9: with LSU_MISALIGN_CHECK_EN -> err=1, rd unchanged;
//    without -> rsp_addr=0x18, rsp_data=0xFFFF_FFFF_FFFF_FF80.
//  5 x2=0xF8, store W off=0x10 -> ea=0x108, err=1, memory at 0x08 unchanged;
//    off=-0x100 (0xFFFF_FFFF_FFFF_FF00) -> ea wraps to 0xFFFF_FFFF_FFFF_FFF8, err=1.
//  6 Accept load, assert rst_n low in MEM -> req_ready=1 and x-regs=0 at release,
//    no rsp_valid; next request completes normally at T+3.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size encoding,
// FSM states, byte-enable / data-mask generation and load extension.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_MEM,
        ST_WB
    } lsu_state_e;

    // Byte lanes touched by an access of the given size, relative to its address.
    function automatic logic [7:0] size_be(input lsu_size_e sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Data mask covering the low 2^size bytes.
    function automatic logic [63:0] size_mask(input lsu_size_e sz);
        case (sz)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return '1;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_lowbits(input lsu_size_e sz);
        case (sz)
            SZ_B:    return 3'd0;
            SZ_H:    return 3'd1;
            SZ_W:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // Sign- or zero-extend the low 2^size bytes of raw to 64 bits.
    function automatic logic [63:0] extend(input logic [63:0] raw, input lsu_size_e sz,
                                           input logic uns);
        case (sz)
            SZ_B:    return uns ? {56'h0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    return uns ? {48'h0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    return uns ? {32'h0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Byte-addressable local data memory: byte-enable write, registered read of
// XLEN/8 consecutive bytes (little-endian). Contents are not reset.
module lsu_dmem #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned MEM_BYTES = 256,
    localparam int unsigned AW       = $clog2(MEM_BYTES),
    localparam int unsigned NB       = XLEN / 8
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic            re_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [NB-1:0]   be_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [7:0]      mem_q [MEM_BYTES];
    logic [XLEN-1:0] rdata_q;

    // Byte-lane write and synchronous read of the addressed word.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (we_i && be_i[i]) begin
                mem_q[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
            end
            if (re_i) begin
                rdata_q[8*i +: 8] <= mem_q[addr_i + AW'(i)];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: register file (x0 = 0) with preload port, effective-address
// generation, sized little-endian access to lsu_dmem, sign/zero-extended loads.
// Four-cycle sequence IDLE -> ADDR -> MEM -> WB with a one-cycle response pulse.
// Build option LSU_MISALIGN_CHECK_EN: misaligned accesses abort with rsp_err;
// when undefined the address is force-aligned instead.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned MEM_BYTES = 256,
    localparam int unsigned RIDX_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [RIDX_W-1:0] rs1,
    input  logic [RIDX_W-1:0] rd_rs2,
    input  logic [XLEN-1:0]   offset,
    input  logic              rf_we,
    input  logic [RIDX_W-1:0] rf_widx,
    input  logic [XLEN-1:0]   rf_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_addr,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned NB = XLEN / 8;

    lsu_state_e        state_q, state_d;
    logic              store_q, uns_q, err_q;
    lsu_size_e         size_q;
    logic [RIDX_W-1:0] rs1_q, rd_q;
    logic [XLEN-1:0]   off_q, ea_q, sdata_q;
    logic [XLEN-1:0]   rf_q [NREGS];
    logic              rsp_valid_q, rsp_err_q;
    logic [XLEN-1:0]   rsp_addr_q, rsp_data_q;

    logic              accept;
    logic [XLEN-1:0]   ea_raw, low_mask, ea_calc, rdata, wb_value;
    logic              err_calc;
    logic [7:0]        be_full;
    logic [63:0]       mask64, ext64;

    assign accept    = (state_q == ST_IDLE) && req_valid;
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = ~req_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: fixed four-cycle sequence once a request is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_ADDR;
            ST_ADDR: state_d = ST_MEM;
            ST_MEM:  state_d = ST_WB;
            default: state_d = ST_IDLE;
        endcase
    end

    // Effective address and abort decision for the latched request.
    always_comb begin
        ea_raw   = rf_q[rs1_q] + off_q;
        low_mask = XLEN'(size_lowbits(size_q));
`ifdef LSU_MISALIGN_CHECK_EN
        ea_calc  = ea_raw;
        err_calc = (|ea_calc[XLEN-1:AW]) || ((XLEN == 32) && (size_q == SZ_D))
                   || (|(ea_raw & low_mask));
`else
        ea_calc  = ea_raw & ~low_mask;
        err_calc = (|ea_calc[XLEN-1:AW]) || ((XLEN == 32) && (size_q == SZ_D));
`endif
    end

    // Write-back value: masked store data or extended load data.
    always_comb begin
        be_full  = size_be(size_q);
        mask64   = size_mask(size_q);
        ext64    = extend(64'(rdata), size_q, uns_q);
        wb_value = store_q ? (sdata_q & mask64[XLEN-1:0]) : ext64[XLEN-1:0];
    end

    // Request capture in IDLE, address/store-data/error capture in ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            rs1_q   <= '0;
            rd_q    <= '0;
            off_q   <= '0;
            ea_q    <= '0;
            sdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                store_q <= req_store;
                uns_q   <= req_unsigned;
                size_q  <= lsu_size_e'(req_size);
                rs1_q   <= rs1;
                rd_q    <= rd_rs2;
                off_q   <= offset;
            end
            if (state_q == ST_ADDR) begin
                ea_q    <= ea_calc;
                sdata_q <= rf_q[rd_q];
                err_q   <= err_calc;
            end
        end
    end

    // Register file: preload in IDLE, load write-back in WB; x0 never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            if ((state_q == ST_IDLE) && rf_we && (rf_widx != '0)) begin
                rf_q[rf_widx] <= rf_wdata;
            end
            if ((state_q == ST_WB) && !store_q && !err_q && (rd_q != '0)) begin
                rf_q[rd_q] <= wb_value;
            end
        end
    end

    // Response registers: valid pulses in WB, other fields hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= (state_q == ST_WB);
            if (state_q == ST_WB) begin
                rsp_addr_q <= ea_q;
                rsp_data_q <= err_q ? '0 : wb_value;
                rsp_err_q  <= err_q;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    lsu_dmem #(
        .XLEN      (XLEN),
        .MEM_BYTES (MEM_BYTES)
    ) u_dmem (
        .clk_i   (clk),
        .we_i    ((state_q == ST_MEM) && store_q && !err_q),
        .re_i    (state_q == ST_MEM),
        .addr_i  (ea_q[AW-1:0]),
        .be_i    (be_full[NB-1:0]),
        .wdata_i (sdata_q),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (XLEN=64, NREGS=32, MEM_BYTES=256).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and
// compares on every rsp_valid pulse, including accept-to-response latency.
module tb_load_store_unit;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]      req_size;
    logic [4:0]      rs1, rd_rs2, rf_widx;
    logic [XLEN-1:0] offset, rf_wdata;
    logic            rf_we;
    logic            rsp_valid, rsp_err, busy;
    logic [XLEN-1:0] rsp_addr, rsp_data;

    load_store_unit #(
        .XLEN      (64),
        .NREGS     (32),
        .MEM_BYTES (256)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rs1          (rs1),
        .rd_rs2       (rd_rs2),
        .offset       (offset),
        .rf_we        (rf_we),
        .rf_widx      (rf_widx),
        .rf_wdata     (rf_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_addr     (rsp_addr),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: accept is seen at the negedge before the accepting posedge, so
    // a response after posedge T+3 is seen four negedges later.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            acc_q.delete();
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_addr"}, rsp_addr, e.addr);
                    check({e.name, "_data"}, rsp_data, e.data);
                    check({e.name, "_err"}, 64'(rsp_err), 64'(e.err));
                    if (acc_q.size() == 0) check({e.name, "_acc"}, 64'(acc_q.size()), 64'd1);
                    else check({e.name, "_lat"}, 64'(cyc - acc_q.pop_front()), 64'd4);
                end
            end
            if (req_valid && req_ready) acc_q.push_back(cyc);
        end
    end

    task automatic preload(input logic [4:0] idx, input logic [63:0] val);
        @(posedge clk); #1;
        rf_we = 1'b1; rf_widx = idx; rf_wdata = val;
        @(posedge clk); #1;
        rf_we = 1'b0;
    endtask

    task automatic issue(input string name, input bit st, input logic [1:0] sz, input bit uns,
                         input logic [4:0] b, input logic [4:0] r, input logic [63:0] off,
                         input bit chk, input logic [63:0] ea, input logic [63:0] d,
                         input bit e);
        bit ok = 1'b0;
        if (chk) exp_q.push_back('{addr: ea, data: d, err: e, name: name});
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
        rs1 = b; rd_rs2 = r; offset = off;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check({name, "_ready_timeout"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    localparam logic [63:0] NEG80 = 64'hFFFF_FFFF_FFFF_FF80;
    localparam logic [63:0] PAT   = 64'h1122_3344_5566_7788;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; rs1 = '0; rd_rs2 = '0; offset = '0;
        rf_we = 1'b0; rf_widx = '0; rf_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_addr", rsp_addr, 64'd0);
        check("rst_data", rsp_data, 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);

        preload(5'd2, 64'h10);
        preload(5'd6, NEG80);
        preload(5'd3, PAT);

        issue("st_pat", 1, 2'b11, 0, 5'd0, 5'd3, 64'h8, 1, 64'h8, PAT, 0);
        wait_done();
        issue("t1_stD", 1, 2'b11, 0, 5'd2, 5'd6, 64'h8, 1, 64'h18, NEG80, 0);
        wait_done();
        repeat (3) @(negedge clk);
        check("hold_valid", 64'(rsp_valid), 64'd0);
        check("hold_addr", rsp_addr, 64'h18);
        check("hold_data", rsp_data, NEG80);

        issue("t2_ldB_s", 0, 2'b00, 0, 5'd2, 5'd7, 64'h8, 1, 64'h18, NEG80, 0);
        issue("t2_x7_s", 1, 2'b11, 0, 5'd0, 5'd7, 64'h30, 1, 64'h30, NEG80, 0);
        issue("t2_ldB_u", 0, 2'b00, 1, 5'd2, 5'd7, 64'h8, 1, 64'h18, 64'h80, 0);
        issue("t2_x7_u", 1, 2'b11, 0, 5'd0, 5'd7, 64'h38, 1, 64'h38, 64'h80, 0);
        issue("ldH_u", 0, 2'b01, 1, 5'd2, 5'd8, 64'h8, 1, 64'h18, 64'hFF80, 0);
        issue("ldW_s", 0, 2'b10, 0, 5'd2, 5'd8, 64'h8, 1, 64'h18, NEG80, 0);
        issue("ldW_u", 0, 2'b10, 1, 5'd0, 5'd8, 64'h8, 1, 64'h8, 64'h5566_7788, 0);
        issue("stB", 1, 2'b00, 0, 5'd0, 5'd3, 64'h40, 1, 64'h40, 64'h88, 0);
        wait_done();

        issue("t3_ldD_x0", 0, 2'b11, 0, 5'd2, 5'd0, 64'h8, 1, 64'h18, NEG80, 0);
        issue("t3_x0", 1, 2'b11, 0, 5'd0, 5'd0, 64'h20, 1, 64'h20, 64'h0, 0);
        wait_done();

`ifdef LSU_MISALIGN_CHECK_EN
        issue("t4_ldH_mis", 0, 2'b01, 0, 5'd2, 5'd9, 64'h9, 1, 64'h19, 64'h0, 1);
        issue("t4_x9", 1, 2'b11, 0, 5'd0, 5'd9, 64'h48, 1, 64'h48, 64'h0, 0);
`else
        issue("t4_ldH_mis", 0, 2'b01, 0, 5'd2, 5'd9, 64'h9, 1, 64'h18, NEG80, 0);
        issue("t4_x9", 1, 2'b11, 0, 5'd0, 5'd9, 64'h48, 1, 64'h48, NEG80, 0);
`endif
        wait_done();

        preload(5'd2, 64'hF8);
        issue("t5_oob", 1, 2'b10, 0, 5'd2, 5'd6, 64'h10, 1, 64'h108, 64'h0, 1);
        issue("t5_wrap", 1, 2'b10, 0, 5'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FF00, 1,
              64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1);
        issue("t5_mem08", 0, 2'b11, 0, 5'd0, 5'd10, 64'h8, 1, 64'h8, PAT, 0);
        issue("stB_last", 1, 2'b00, 0, 5'd0, 5'd3, 64'hFF, 1, 64'hFF, 64'h88, 0);
        issue("ldB_last", 0, 2'b00, 1, 5'd0, 5'd11, 64'hFF, 1, 64'hFF, 64'h88, 0);
        issue("ldB_end", 0, 2'b00, 1, 5'd0, 5'd11, 64'h100, 1, 64'h100, 64'h0, 1);
        wait_done();

        // Abort a load in MEM with reset; nothing may respond.
        issue("t6_abort", 0, 2'b11, 0, 5'd2, 5'd12, 64'h8, 0, 64'h0, 64'h0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_ready", 64'(req_ready), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue("t6_after", 1, 2'b11, 0, 5'd2, 5'd6, 64'h0, 1, 64'h0, 64'h0, 0);
        wait_done();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
